// File: rtl/gate_test_pkg.sv
// gate_test_pkg: gate opcodes, FSM state encoding and settle default for the gate tester
package gate_test_pkg;
  localparam logic [2:0] G_AND  = 3'd0;
  localparam logic [2:0] G_OR   = 3'd1;
  localparam logic [2:0] G_NAND = 3'd2;
  localparam logic [2:0] G_NOR  = 3'd3;
  localparam logic [2:0] G_XOR  = 3'd4;
  localparam logic [2:0] G_XNOR = 3'd5;
  localparam int SETTLE_CYC_DEF = 2;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden output of the selected 3-input gate for a vector
module gate_ref_model
  import gate_test_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic [2:0] idx,
  output logic       exp_out
);
  // illegal opcodes map to 0; the controller never samples them
  always_comb
    exp_out = gate_sel == G_AND  ?  (&idx) :
              gate_sel == G_OR   ?  (|idx) :
              gate_sel == G_NAND ? ~(&idx) :
              gate_sel == G_NOR  ? ~(|idx) :
              gate_sel == G_XOR  ?  (^idx) :
              gate_sel == G_XNOR ? ~(^idx) : 1'b0;
endmodule

// File: rtl/gate_test_ctrl.sv
// gate_test_ctrl: exhaustive 8-vector tester for a 3-input gate; define GATE_TEST_STOP_ON_FAIL_EN to stop at the first mismatch
module gate_test_ctrl
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_out,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_mask
);
`ifdef GATE_TEST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  state_t     state;
  logic [2:0] sel, idx;
  logic [3:0] cnt;
  logic       ref_out, miss;
  gate_ref_model u_ref (.gate_sel(sel), .idx(idx), .exp_out(ref_out));
  assign miss = dut_out != ref_out;
  // test sequencer; done is a registered pulse one cycle after the DONE state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      sel             <= 3'd0;
      idx             <= 3'd0;
      cnt             <= 4'd0;
      {in2, in1, in0} <= 3'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= 4'd0;
      fail_mask       <= 8'h00;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          sel             <= gate_sel;
          idx             <= 3'd0;
          cnt             <= 4'd0;
          {in2, in1, in0} <= 3'd0;
          busy            <= 1'b1;
          pass            <= 1'b0;
          err_cnt         <= 4'd0;
          fail_mask       <= gate_sel > G_XNOR ? 8'hFF : 8'h00;
          state           <= gate_sel > G_XNOR ? DONE : APPLY;
        end
        APPLY: begin
          cnt   <= cnt == 4'(SETTLE_CYC - 1) ? 4'd0 : cnt + 4'd1;
          state <= cnt == 4'(SETTLE_CYC - 1) ? SAMPLE : APPLY;
        end
        SAMPLE: begin
          if (miss) begin
            err_cnt        <= err_cnt + 4'd1;
            fail_mask[idx] <= 1'b1;
          end
          if (idx == 3'd7 || (STOP && miss)) begin
            {in2, in1, in0} <= 3'd0;
            state           <= DONE;
          end else begin
            idx             <= idx + 3'd1;
            {in2, in1, in0} <= idx + 3'd1;
            state           <= APPLY;
          end
        end
        DONE: begin
          pass  <= err_cnt == 4'd0 && fail_mask == 8'h00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_gate_test_ctrl.sv
// tb_gate_test_ctrl: randomized and directed checks of gate_test_ctrl against a truth-table model
module tb_gate_test_ctrl;
  localparam int S = 2;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, dut_out;
  logic [2:0] gate_sel = 3'd0;
  logic in0, in1, in2, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_mask;
  logic [7:0] flip = 8'h00, tcur;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  gate_test_ctrl #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .dut_out(dut_out),
    .in0(in0), .in1(in1), .in2(in2), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_mask(fail_mask)
  );

  function automatic logic [7:0] tt(input logic [2:0] g);
    logic [7:0] r;
    int pc;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pc = $countones(3'(i));
      case (g)
        3'd0: r[i] = pc == 3;
        3'd1: r[i] = pc > 0;
        3'd2: r[i] = pc != 3;
        3'd3: r[i] = pc == 0;
        3'd4: r[i] = pc % 2 == 1;
        3'd5: r[i] = pc % 2 == 0;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // emulated gate under test: ideal truth table with selected vectors inverted
  always_comb begin
    tcur = tt(gate_sel);
    dut_out = tcur[{in2, in1, in0}] ^ flip[{in2, in1, in0}];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] g, input logic [7:0] f, input bit intrude);
    int el, ee, n;
    logic [7:0] em;
    logic ep;
    em = 8'h00; ee = 0;
    if (g > 3'd5) begin
      el = 1; em = 8'hFF;
    end else begin
      el = 8 * (S + 1) + 1;
      for (int k = 0; k < 8; k++)
        if (f[k]) begin
          em[k] = 1'b1;
          ee++;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
          el = (k + 1) * (S + 1) + 1;
          break;
`endif
        end
    end
    ep = g <= 3'd5 && ee == 0;
    gate_sel = g; flip = f;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (n < 200 && !done) begin
      @(posedge clk);
      #1;
      n++;
      start = intrude && n == 5;
      if (!done)
        chk("vector", {in2, in1, in0}, (g <= 3'd5 && n < el - 1) ? n / (S + 1) : 0);
    end
    chk("latency", n, el);
    chk("pass", pass, ep);
    chk("err_cnt", err_cnt, ee);
    chk("fail_mask", fail_mask, em);
    chk("busy_at_done", busy, 0);
    start = 1'b0;
    @(posedge clk);
    #1 chk("done_pulse_width", done, 0);
  endtask

  initial begin
    int n;
    bit saw;
    #2 rst = 1'b1;
    #1;
    chk("rst_vec", {in2, in1, in0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_mask", fail_mask, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run(3'd0, 8'h00, 1'b0);
    run(3'd0, 8'h80, 1'b0);
    run(3'd1, tt(3'd1) ^ tt(3'd0), 1'b0);
    run(3'd0, ~tt(3'd0), 1'b0);
    run(3'd6, 8'h00, 1'b0);
    run(3'd7, 8'h3C, 1'b0);
    run(3'd4, 8'h00, 1'b1);
    run(3'd5, 8'h81, 1'b1);
    for (int i = 0; i < 20; i++)
      run(3'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), i % 3 == 0);

    gate_sel = 3'd0; flip = 8'h07;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3 * (S + 1) + 1) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort_vec", {in2, in1, in0}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err_cnt, 0);
    chk("abort_mask", fail_mask, 0);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk);
      #1 saw |= done;
    end
    chk("abort_no_done", saw, 0);
    run(3'd0, 8'h07, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_test_ctrl.md
GATE_TEST_CTRL -- requirements
Module: gate_test_ctrl

Interface
REQ-001 SETTLE_CYC, 2, cycles each vector is held before the DUT output is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to run a full 8-vector test.
REQ-005 gate_sel  input  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR (odd parity), 5 XNOR; 6 and 7 are illegal.
REQ-006 dut_out  input  1  output of the 3-input gate under test.
REQ-007 in0, in1, in2  output  1 each  stimulus to the DUT; vector index idx = {in2,in1,in0}.
REQ-008 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 pass  output  1  high when the last run had zero mismatches; held until the next accepted start.
REQ-011 err_cnt  output  4  mismatch count of the last run (0..8).
REQ-012 fail_mask  output  8  bit k set when vector k mismatched.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, SAMPLE and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted: latch gate_sel, clear err_cnt, fail_mask and pass, set idx=0, go to APPLY.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 APPLY SHALL drive {in2,in1,in0}=idx for exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle, holding the same vector, and compare dut_out with the reference result for the latched gate and idx.
REQ-018 On mismatch, SAMPLE SHALL increment err_cnt and set fail_mask[idx].
REQ-019 After SAMPLE: if idx=7, go to DONE; otherwise increment idx and go to APPLY.
REQ-020 DONE SHALL last 1 cycle with done=1 and pass=(err_cnt==0), then go to IDLE.
REQ-021 Latency: done SHALL be high in the cycle following rising edge 8*(SETTLE_CYC+1)+1 after the edge that accepted start.
REQ-022 If start is accepted with gate_sel=6 or 7, the FSM SHALL go directly to DONE with pass=0, err_cnt=0 and fail_mask=8'hFF.
REQ-023 in0..in2 SHALL be 0 in IDLE and DONE.

Reset
REQ-024 On rst=1, the block SHALL asynchronously enter IDLE.
REQ-025 Reset SHALL force idx=0, in0..in2=0, busy=0, done=0, pass=0, err_cnt=0 and fail_mask=0.
REQ-026 Reset asserted mid-run SHALL abort the run with no done pulse.

Configuration
REQ-027 With GATE_TEST_STOP_ON_FAIL_EN defined, the first mismatch in SAMPLE SHALL go to DONE immediately, leaving later fail_mask bits 0.
REQ-028 Without GATE_TEST_STOP_ON_FAIL_EN, all 8 vectors SHALL always be applied.

Structure
REQ-029 Package gate_test_pkg SHALL hold the gate_sel opcode constants, the FSM state encoding and the SETTLE_CYC default.
REQ-030 Sub-module gate_ref_model SHALL be purely combinational, mapping (gate_sel, idx) to the expected output.

Verification
REQ-031 gate_sel=0, dut_out an ideal AND, SETTLE_CYC=2, start pulse -> done at edge 25, pass=1, err_cnt=0, fail_mask=8'h00.
REQ-032 gate_sel=0, dut_out stuck at 0 -> err_cnt=1, fail_mask=8'h80, pass=0.
REQ-033 gate_sel=1 with dut_out driven by an AND -> err_cnt=6, fail_mask=8'h7E.
REQ-034 GATE_TEST_STOP_ON_FAIL_EN defined, gate_sel=0, dut_out stuck at 1 -> done at edge 4, err_cnt=1, fail_mask=8'h01.
REQ-035 gate_sel=6 start -> done on the next cycle, pass=0, fail_mask=8'hFF; a start pulse while busy -> ignored, done timing unchanged.
REQ-036 rst pulse during vector 3 -> all outputs 0 immediately and no done; a fresh start then completes normally.
